// File: rtl/md_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM state encoding, write-back kinds and the divide-by-zero LO value.
package md_seq_pkg;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_DIV   = 3'd1;
   localparam logic [2:0] OP_DIVU  = 3'd2;
   localparam logic [2:0] OP_MULTU = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_DIV,
      ST_WAIT_MUL,
      ST_WRITE
   } md_state_e;

   // What the WRITE state commits; WR_ABORT marks a divider timeout.
   typedef enum logic [2:0] {
      WR_DIV,
      WR_DIVU,
      WR_MULTU,
      WR_DBZ,
      WR_ABORT
   } md_wr_e;

   localparam logic [31:0] DBZ_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/md_wait_cnt.sv
// Clearable, saturating up-counter with a terminal-count compare; shared by
// the multiplier latency wait and the divider timeout.
module md_wait_cnt #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] term_i,
   output logic             hit_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign hit_o = (cnt_q == term_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !hit_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/md_seq_ctrl.sv
// HI/LO sequencer: accepts DIV/DIVU/MULTU/MTHI/MTLO, launches the selected
// arithmetic unit, stalls the PC until its result is ready, then commits HI/LO.
module md_seq_ctrl
   import md_seq_pkg::*;
#(
   parameter int MUL_LAT     = 1,
   parameter int DIV_TIMEOUT = 63,
   parameter int CNT_W       = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_start,
   output logic        divu_start,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   input  logic        div_busy,
   input  logic        divu_busy,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   input  logic [31:0] divu_q,
   input  logic [31:0] divu_r,
   input  logic [63:0] multu_z,
   output logic        timeout_err
);

   localparam logic [CNT_W-1:0] MUL_TERM = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_TERM = CNT_W'(DIV_TIMEOUT - 1);

   md_state_e   state_q, state_d;
   md_wr_e      wr_q, wr_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        busy_seen_q, busy_seen_d;
   logic        tmo_q, tmo_d;

   logic             cnt_clr;
   logic             cnt_en;
   logic [CNT_W-1:0] cnt_term;
   logic             cnt_hit;
   logic             unit_busy;

   md_wait_cnt #(
      .CNT_W (CNT_W)
   ) u_wait_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (cnt_clr),
      .en_i   (cnt_en),
      .term_i (cnt_term),
      .hit_o  (cnt_hit)
   );

   assign unit_busy = (wr_q == WR_DIVU) ? divu_busy : div_busy;

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statements can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      a_d         = a_q;
      b_d         = b_q;
      busy_seen_d = busy_seen_q;
      tmo_d       = tmo_q;
      stall       = 1'b0;
      done        = 1'b0;
      div_start   = 1'b0;
      divu_start  = 1'b0;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;
      cnt_term    = DIV_TERM;

      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (op_valid) begin
               case (op)
                  OP_MTHI: hi_d = rs_data;
                  OP_MTLO: lo_d = rs_data;
                  OP_DIV, OP_DIVU: begin
                     stall = 1'b1;
                     a_d   = rs_data;
                     b_d   = rt_data;
                     if (rt_data == '0) begin
                        wr_d    = WR_DBZ;
                        state_d = ST_WRITE;
                     end else begin
                        wr_d    = (op == OP_DIV) ? WR_DIV : WR_DIVU;
                        state_d = ST_START;
                     end
                  end
                  OP_MULTU: begin
                     stall   = 1'b1;
                     a_d     = rs_data;
                     b_d     = rt_data;
                     wr_d    = WR_MULTU;
                     state_d = ST_WAIT_MUL;
                  end
                  default: ;
               endcase
            end
         end

         ST_START: begin
            stall       = 1'b1;
            div_start   = (wr_q == WR_DIV);
            divu_start  = (wr_q == WR_DIVU);
            busy_seen_d = 1'b0;
            cnt_clr     = 1'b1;
            state_d     = ST_WAIT_DIV;
         end

         ST_WAIT_DIV: begin
            stall  = 1'b1;
            cnt_en = 1'b1;
            if (unit_busy) begin
               busy_seen_d = 1'b1;
            end
            // A falling busy only counts once the unit has been seen busy.
            if (busy_seen_q && !unit_busy) begin
               state_d = ST_WRITE;
            end else if (cnt_hit) begin
               tmo_d   = 1'b1;
               wr_d    = WR_ABORT;
               state_d = ST_WRITE;
            end
         end

         ST_WAIT_MUL: begin
            stall    = 1'b1;
            cnt_en   = 1'b1;
            cnt_term = MUL_TERM;
            if (cnt_hit) begin
               state_d = ST_WRITE;
            end
         end

         ST_WRITE: begin
            done    = (wr_q != WR_ABORT);
            state_d = ST_IDLE;
            case (wr_q)
               WR_DIV: begin
                  hi_d = div_r;
                  lo_d = div_q;
               end
               WR_DIVU: begin
                  hi_d = divu_r;
                  lo_d = divu_q;
               end
               WR_MULTU: begin
                  hi_d = multu_z[63:32];
                  lo_d = multu_z[31:0];
               end
               WR_DBZ: begin
                  hi_d = a_q;
                  lo_d = DBZ_LO;
               end
               default: ;
            endcase
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         wr_q        <= WR_DIV;
         hi_q        <= '0;
         lo_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         busy_seen_q <= 1'b0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         a_q         <= a_d;
         b_q         <= b_d;
         busy_seen_q <= busy_seen_d;
         tmo_q       <= tmo_d;
      end
   end

   assign hi          = hi_q;
   assign lo          = lo_q;
   assign md_a        = a_q;
   assign md_b        = b_q;
   assign timeout_err = tmo_q;

endmodule
